// File: rtl/hls_macc_pkg.sv
// Shared types and helpers for the key-locked pipelined MAC engine.
package hls_macc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int WKEY_W   = 6;
  localparam int KEY_INIT = 0;
  localparam int KEY_DONE = 1;
  localparam int KEY_ILL  = 2;
  localparam int KEY_MUL  = 3;
  localparam int KEY_SUB  = 4;
  localparam int KEY_SHF  = 5;

  // Widest accumulator-plus-guard-bit value the clamp helper can handle.
  localparam int SAT_MAX_W = 128;

  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/hls_macc_dp.sv
// Two-stage MAC datapath: keyed operator select, then keyed accumulate.
// HLS_MACC_SAT_EN selects clamping of the accumulator instead of wrapping.
module hls_macc_dp
  import hls_macc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     k_mul,
  input  logic                     k_sub,
  input  logic                     k_shf,
  input  logic                     acc_load,
  input  logic signed [ACC_W-1:0]  acc_init,
  input  logic                     beat_vld,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     vld_p1
);

  localparam int PW = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("hls_macc_dp: ACC_W must be at least 2*DATA_W");
  end
  if (ACC_W + 1 > SAT_MAX_W) begin : g_bad_sat_w
    $error("hls_macc_dp: ACC_W too wide for the clamp helper");
  end

  function automatic logic signed [ACC_W-1:0] acc_fit(input logic signed [ACC_W:0] s);
`ifdef HLS_MACC_SAT_EN
    return ACC_W'(sat_clamp(SAT_MAX_W'(s), ACC_W));
`else
    return ACC_W'(s);
`endif
  endfunction

  logic signed [PW-1:0]  a_x;
  logic signed [PW-1:0]  b_x;
  logic signed [PW-1:0]  prod_p0;
  logic signed [PW-1:0]  p_p0;
  logic signed [PW-1:0]  p_p1;
  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] p_x;
  logic signed [ACC_W:0] sum_p1;

  // Stage 1: operator select and optional halving
  assign a_x     = PW'(a);
  assign b_x     = PW'(b);
  assign prod_p0 = k_mul ? (a_x * b_x) : (a_x + b_x);
  assign p_p0    = k_shf ? prod_p0 : (prod_p0 >>> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= beat_vld;
  end

  always_ff @(posedge clk) begin
    p_p1 <= p_p0;
  end

  // Stage 2: accumulate one guard bit wide, then wrap or clamp
  assign acc_x  = (ACC_W + 1)'(acc);
  assign p_x    = (ACC_W + 1)'(p_p1);
  assign sum_p1 = k_sub ? (acc_x - p_x) : (acc_x + p_x);

  // The accumulator doubles as the visible result, so it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (acc_load) acc <= acc_init;
    else if (vld_p1)   acc <= acc_fit(sum_p1);
  end

endmodule

// File: rtl/hls_macc_pipe_obf.sv
// Key-locked MAC engine top: ap_ctrl_hs FSM, beat counter, operand handshake.
// HLS_MACC_SAT_EN (in hls_macc_dp) enables accumulator saturation.
module hls_macc_pipe_obf
  import hls_macc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 64
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  input  logic signed [ACC_W-1:0]  acc_init,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_acc_ap_vld,
  input  logic [KEY_W-1:0]         locking_key
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("hls_macc_pipe_obf: DEPTH must be at least 1");
  end
  if (KEY_W < WKEY_W) begin : g_bad_key_w
    $error("hls_macc_pipe_obf: KEY_W must be at least 6");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WKEY_W-1:0]  wkey;
  logic               beat_acc;
  logic               last_beat;
  logic               vld_p1;
  logic               unused_key;

  assign wkey       = locking_key[WKEY_W-1:0];
  assign unused_key = ^locking_key;
  assign beat_acc   = in_vld & in_rdy;
  assign last_beat  = beat_acc && (cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_INIT;
      S_INIT:  state_nxt = wkey[KEY_INIT] ? S_INIT : S_RUN;
      S_RUN:   if (last_beat) state_nxt = S_DRAIN;
      // Stage 2 absorbs the final product on the same edge that leaves DRAIN.
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = wkey[KEY_DONE] ? S_IDLE : S_INIT;
      default: state_nxt = wkey[KEY_ILL] ? S_RUN : S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                            cnt <= '0;
    else if (state == S_INIT)              cnt <= '0;
    else if (state == S_RUN && beat_acc)   cnt <= cnt + CNT_W'(1);
  end

  assign in_rdy         = (state == S_RUN) && (cnt < CNT_W'(DEPTH));
  assign ap_idle        = (state == S_IDLE);
  assign ap_done        = (state == S_DONE);
  assign ap_ready       = (state == S_DONE);
  assign out_acc_ap_vld = (state == S_DONE);

  hls_macc_dp #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .k_mul    (wkey[KEY_MUL]),
    .k_sub    (wkey[KEY_SUB]),
    .k_shf    (wkey[KEY_SHF]),
    .acc_load (state == S_INIT),
    .acc_init (acc_init),
    .beat_vld (beat_acc),
    .a        (in_a),
    .b        (in_b),
    .acc      (out_acc),
    .vld_p1   (vld_p1)
  );

endmodule

// File: tb/tb_hls_macc_pipe_obf.sv
// Directed bench for hls_macc_pipe_obf (DATA_W=16, ACC_W=40, DEPTH=4).
module tb_hls_macc_pipe_obf;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               ap_start;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic signed [39:0] acc_init;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_vld;
  logic               in_rdy;
  logic signed [39:0] out_acc;
  logic               out_acc_ap_vld;
  logic [63:0]        locking_key;

  int checks   = 0;
  int failures = 0;
  int va[4];
  int vb[4];
  int rdy_seen;
  int misalign;

  longint res;
  int     lat;
  int     ndone;

  localparam logic [63:0] KEY_OK = 64'hA5A5_0000_0000_002A;

  hls_macc_pipe_obf #(
    .DATA_W (16),
    .ACC_W  (40),
    .DEPTH  (4),
    .KEY_W  (64)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .acc_init       (acc_init),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .out_acc        (out_acc),
    .out_acc_ap_vld (out_acc_ap_vld),
    .locking_key    (locking_key)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
    va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
  endtask

  // One operation; outputs observed on falling edges, lat counts rising edges from start.
  task automatic run_op(input longint init, input int gap, input int limit, input int stop_idx,
                        output longint r, output int l, output int nd);
    int   idx;
    int   post;
    bit   seen;
    logic hs;
    idx = 0; post = 0; seen = 0; hs = 1'b0;
    r = 0; l = -1; nd = 0; rdy_seen = 0; misalign = 0;
    @(negedge ap_clk);
    acc_init = 40'(init);
    ap_start = 1'b1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (cyc > 0) begin
        @(negedge ap_clk);
        ap_start = 1'b0;
        if (hs) idx++;
        if (in_rdy) rdy_seen++;
        if (ap_done !== ap_ready || ap_done !== out_acc_ap_vld) misalign++;
        if (ap_done) begin
          nd++;
          if (!seen) begin
            l = cyc;
            r = out_acc;
            seen = 1;
          end
        end
        if (seen) post++;
        if (post > 3) break;
        if (stop_idx > 0 && idx == stop_idx) break;
      end
      in_vld = !seen && (gap == 0 || (cyc % 2 == 1));
      if (idx >= 0 && idx < 4) begin
        in_a = 16'(va[idx]);
        in_b = 16'(vb[idx]);
      end else begin
        in_a = 16'sd99;
        in_b = 16'sd99;
      end
      hs = in_vld && in_rdy;
    end
    in_vld   = 1'b0;
    ap_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; in_vld = 1'b0;
    in_a = '0; in_b = '0; acc_init = '0; locking_key = KEY_OK;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_ovld", out_acc_ap_vld, 0);
    chk("rst_rdy", in_rdy, 0);
    chk("rst_acc", out_acc, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("post_rst_idle", ap_idle, 1);

    set_vec(1, 3, 5, 7, 2, 4, 6, 8);
    run_op(0, 0, 40, 0, res, lat, ndone);
    chk("basic_acc", res, 100);
    chk("basic_lat", lat, 7);
    chk("basic_ndone", ndone, 1);
    chk("basic_align", misalign, 0);
    chk("basic_hold", out_acc, 100);
    chk("basic_idle", ap_idle, 1);

    set_vec(-3, -3, -3, -3, 5, 5, 5, 5);
    run_op(10, 0, 40, 0, res, lat, ndone);
    chk("seed_acc", res, -50);
    chk("seed_lat", lat, 7);

    set_vec(1, 3, 5, 7, 2, 4, 6, 8);
    run_op(0, 1, 60, 0, res, lat, ndone);
    chk("bp_acc", res, 100);
    chk("bp_lat", lat, 11);
    chk("bp_ndone", ndone, 1);

    set_vec(100, 0, 0, 0, 100, 0, 0, 0);
    run_op((longint'(1) <<< 39) - 11, 0, 40, 0, res, lat, ndone);
`ifdef HLS_MACC_SAT_EN
    chk("ovf_sat", res, (longint'(1) <<< 39) - 1);
`else
    chk("ovf_wrap", res, -(longint'(1) <<< 39) + 9989);
`endif

    locking_key = 64'hA5A5_0000_0000_002B;
    set_vec(1, 3, 5, 7, 2, 4, 6, 8);
    run_op(0, 0, 100, 0, res, lat, ndone);
    chk("k2b_ndone", ndone, 0);
    chk("k2b_rdy", rdy_seen, 0);
    chk("k2b_lat", lat, -1);
    chk("k2b_idle", ap_idle, 0);
    locking_key = KEY_OK;
    pulse_reset();

    locking_key = 64'hA5A5_0000_0000_0022;
    run_op(0, 0, 40, 0, res, lat, ndone);
    chk("k22_acc", res, 36);
    chk("k22_ndone", ndone, 1);
    locking_key = KEY_OK;

    run_op(0, 0, 40, 2, res, lat, ndone);
    ap_rst = 1'b1;
    #1;
    chk("mrst_idle", ap_idle, 1);
    chk("mrst_acc", out_acc, 0);
    chk("mrst_rdy", in_rdy, 0);
    chk("mrst_done", ap_done, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge ap_clk);
      if (ap_done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    run_op(0, 0, 40, 0, res, lat, ndone);
    chk("mrst_rerun", res, 100);
    chk("mrst_rerun_lat", lat, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_macc_pipe_obf.md
# hls_macc_pipe_obf

Parametrised, logic-locked multiply-accumulate engine with `ap_ctrl_hs` block handshake and a valid/ready operand stream. It is the next generation of the key-obfuscated HLS MAC cores. It generalises data width, accumulator width and term count, and adds a two-stage datapath pipeline, input backpressure and optional saturation. A working-key slice of `locking_key` gates the FSM transitions and the datapath operator choice, so only the correct key yields MAC behaviour.

## Interface
Parameters:
- `DATA_W`, 16: signed operand width.
- `ACC_W`, 40: signed accumulator width. Must satisfy ACC_W ≥ 2·DATA_W; elaboration error otherwise.
- `DEPTH`, 8: operand pairs per operation, ≥1.
- `KEY_W`, 64: `locking_key` width, ≥6. Only bits [5:0] form `working_key`.

Ports:
- `ap_clk`, in, 1: clock. Single clock domain; everything is on the rising edge.
- `ap_rst`, in, 1: reset, asynchronous, active-high.
- `ap_start`, in, 1: start request.
- `ap_done`, out, 1: one-cycle completion pulse.
- `ap_idle`, out, 1: FSM is in S_IDLE.
- `ap_ready`, out, 1: one-cycle pulse, concurrent with `ap_done`.
- `acc_init`, in, ACC_W: accumulator seed, sampled in S_INIT.
- `in_a`, `in_b`, in, DATA_W: operand pair.
- `in_vld`, in, 1: operand pair valid.
- `in_rdy`, out, 1: operand pair accepted when `in_vld & in_rdy`.
- `out_acc`, out, ACC_W: result. Held until the next S_INIT.
- `out_acc_ap_vld`, out, 1: one-cycle result-valid pulse.
- `locking_key`, in, KEY_W: locking key. The correct value of [5:0] is 6'h2A.

## Operation
- FSM states: S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE. Encoding is binary.
- S_IDLE → S_INIT when `ap_start`=1.
- S_INIT: load acc ← `acc_init` and clear the beat counter. Go to S_RUN if k[0]=0; stay in S_INIT if k[0]=1.
- S_RUN: `in_rdy`=1 while count<DEPTH. Each accepted beat increments count. When the DEPTH-th beat is accepted, go to S_DRAIN.
- S_DRAIN: wait until the pipeline is empty (one cycle), then go to S_DONE.
- S_DONE: assert `ap_done`, `ap_ready` and `out_acc_ap_vld`. Go to S_IDLE if k[1]=1, or to S_INIT if k[1]=0 (spurious re-run).
- Illegal encoding: go to S_IDLE if k[2]=0, to S_RUN if k[2]=1.
- Stage 1, registered: p = k[3] ? a·b : sext(a)+sext(b). Result is 2·DATA_W bits, signed. Then p' = k[5] ? p : p>>>1.
- Stage 2, registered: acc = k[4] ? acc − sext(p') : acc + sext(p'). The sum is computed at ACC_W+1 bits and then wrapped or saturated (see Configuration).
- `out_acc` tracks acc. `ap_idle` is combinational from the state.

## Timing
- Reset values: `ap_done`=0, `ap_ready`=0, `out_acc_ap_vld`=0, `in_rdy`=0, `out_acc`=0, `ap_idle`=1. Pipeline valid bits and count are 0.
- `ap_start` is sampled only in S_IDLE. `ap_start` held high after S_DONE starts the next operation immediately.
- Latency (correct key, no stalls): `ap_start` edge → S_INIT (1 cycle) → DEPTH RUN cycles → S_DRAIN (1 cycle) → S_DONE. Total DEPTH+3 cycles from start to `ap_done`.
- Gaps in `in_vld` stretch S_RUN 1:1. The stage-1 valid bit follows the accepted beat; a bubble adds nothing to acc.
- `in_rdy` is deasserted in S_DRAIN and S_DONE. Beats presented there are not consumed.
- Reset asserted mid-operation: immediate return to S_IDLE. In-flight products are discarded and no `ap_done` is issued.

## Configuration
- `HLS_MACC_SAT_EN` defined: the stage-2 result clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- `HLS_MACC_SAT_EN` undefined: two's-complement wrap to ACC_W bits.

## Structure
- Package `hls_macc_pkg` holds:
  - the state enum;
  - working-key bit-index localparams (KEY_INIT=0, KEY_DONE=1, KEY_ILL=2, KEY_MUL=3, KEY_SUB=4, KEY_SHF=5);
  - the saturation helper function.
- Sub-module `hls_macc_dp` contains the two-stage datapath (operator selection, accumulate, saturation). The top level contains the FSM, counter and handshake logic.

## Test plan
All scenarios use DATA_W=16, ACC_W=40, DEPTH=4, key 0x2A unless stated otherwise.
- Basic MAC: `acc_init`=0, pairs (1,2),(3,4),(5,6),(7,8) with no gaps → `out_acc`=100. `ap_done`/`ap_ready`/`out_acc_ap_vld` pulse once, 7 cycles after start.
- Signed seed: `acc_init`=10, four pairs (−3,5) → `out_acc`=−50.
- Backpressure: same stimulus as Basic MAC with `in_vld` low on alternate cycles → `out_acc`=100, `ap_done` 4 cycles later than Basic MAC. Beats offered in S_DRAIN are not consumed.
- Overflow, `acc_init`=2^39−11, pair (100,100) then three pairs (0,0):
  - macro defined → `out_acc`=2^39−1;
  - macro undefined → `out_acc`=−2^39+9989.
- Wrong key:
  - 0x2B → FSM stays in S_INIT; `in_rdy`=0 and no `ap_done` within 100 cycles.
  - 0x22 with the Basic MAC stimulus → `out_acc`=36 (sum of a+b).
- Reset mid-run: assert `ap_rst` after 2 accepted beats → `ap_idle`=1, `out_acc`=0. Rerunning Basic MAC then gives 100.
